// File: rtl/csd_pkg.sv
// Shared definitions for the CSD coefficient datapath (binary-to-CSD converter and serial MAC).
// Holds the MAC state enum, the per-digit encoding and the default operand sizes.
package csd_pkg;

  localparam int CSD_N = 16;
  localparam int CSD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit encoding as {neg, pos}; the overlapping pattern 2'b11 is treated as zero.
  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_POS  = 2'b01,
    DIG_NEG  = 2'b10
  } digit_e;

  function automatic digit_e digit_of(input logic pos, input logic neg);
    digit_e d;
    d = DIG_ZERO;
    if (pos && !neg) d = DIG_POS;
    if (neg && !pos) d = DIG_NEG;
    return d;
  endfunction

endpackage

// File: rtl/csd_digit_scan.sv
// Combinational lowest-set-bit finder over an N-bit digit mask.
// Used by csd_serial_mac only when CSD_SKIP_ZERO_EN is defined.
module csd_digit_scan #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IW'(i);
    end
    any_o = |mask_i;
  end

endmodule

// File: rtl/csd_serial_mac.sv
// Serial CSD multiplier: one coefficient digit per cycle, shifted add/subtract into an accumulator.
// Build option CSD_SKIP_ZERO_EN: jump straight to the next nonzero digit instead of stepping linearly.
module csd_serial_mac
  import csd_pkg::*;
#(
  parameter int N = CSD_N,
  parameter int W = CSD_W,
  parameter int P = W + N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  input  logic [N-1:0]        csd_pos,
  input  logic [N-1:0]        csd_neg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [P-1:0] y,
  output logic                csd_err,
  output logic [1:0]          dbg_state_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap and
  // a new operand is accepted at the earliest one cycle after the result is taken.

  state_e              state_q, state_d;
  logic signed [P-1:0] x_q, x_d;
  logic signed [P-1:0] acc_q, acc_d;
  logic signed [P-1:0] y_q, y_d;
  logic [N-1:0]        pos_q, pos_d;
  logic [N-1:0]        neg_q, neg_d;
  logic                err_q, err_d;
  logic                y_err_q, y_err_d;

  logic [IW-1:0]       dig_idx;
  logic                dig_en;
  logic                last_dig;
  logic signed [P-1:0] term;

`ifdef CSD_SKIP_ZERO_EN
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  mask_clr;
  logic [IW-1:0] scan_idx;
  logic          scan_any;

  csd_digit_scan #(
    .N (N),
    .IW(IW)
  ) u_scan (
    .mask_i(mask_q),
    .idx_o (scan_idx),
    .any_o (scan_any)
  );

  // An empty mask still spends one RUN cycle; nothing is added because dig_en is low.
  assign dig_idx  = scan_idx;
  assign dig_en   = scan_any;
  assign mask_clr = mask_q & ~(N'(1) << scan_idx);
  assign last_dig = (mask_clr == '0);
`else
  logic [IW-1:0] idx_q, idx_d;

  assign dig_idx  = idx_q;
  assign dig_en   = 1'b1;
  assign last_dig = (idx_q == IW'(N - 1));
`endif

  assign term = x_q << dig_idx;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    y_d     = y_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    err_d   = err_q;
    y_err_d = y_err_q;
`ifdef CSD_SKIP_ZERO_EN
    mask_d  = mask_q;
`else
    idx_d   = idx_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = {{(P - W){x[W-1]}}, x};
          pos_d   = csd_pos;
          neg_d   = csd_neg;
          err_d   = |(csd_pos & csd_neg);
          acc_d   = '0;
`ifdef CSD_SKIP_ZERO_EN
          mask_d  = csd_pos ^ csd_neg;
`else
          idx_d   = '0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dig_en) begin
          case (digit_of(pos_q[dig_idx], neg_q[dig_idx]))
            DIG_POS: acc_d = acc_q + term;
            DIG_NEG: acc_d = acc_q - term;
            default: acc_d = acc_q;
          endcase
        end
`ifdef CSD_SKIP_ZERO_EN
        mask_d = mask_clr;
`else
        idx_d  = idx_q + IW'(1);
`endif
        if (last_dig) begin
          y_d     = acc_d;
          y_err_d = err_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      err_q   <= 1'b0;
      y_err_q <= 1'b0;
`ifdef CSD_SKIP_ZERO_EN
      mask_q  <= '0;
`else
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      y_err_q <= y_err_d;
`ifdef CSD_SKIP_ZERO_EN
      mask_q  <= mask_d;
`else
      idx_q   <= idx_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign y           = y_q;
  assign csd_err     = y_err_q;
  assign dbg_state_o = state_q;

endmodule
